// File: rtl/pipe_receive_fifo_pkg.sv
// Shared link configuration for both ends of the hyperpiped data link.
// Sender and receiver import this so their latency and threshold math agree.
package pipe_receive_fifo_pkg;

  localparam int DEF_WIDTH          = 32;
  localparam int DEF_DEPTH_LOG2     = 5;
  localparam int DEF_FORWARD_CYCLES = 3;
  localparam int DEF_RETURN_CYCLES  = 3;

  // Classifies the pointer/occupancy update for one cycle.
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2,
    OP_BOTH = 2'd3
  } occ_op_e;

  // Free entries must cover every word that can still land after the
  // flag is raised: forward flight, return flight, plus the two
  // registers (flag and sender reaction).
  function automatic int calc_threshold(
    input int depth_log2,
    input int fwd_cycles,
    input int ret_cycles
  );
    return (2 ** depth_log2) - (fwd_cycles + ret_cycles + 2);
  endfunction

endpackage

// File: rtl/enabledShiftRegister.sv
// Clock-enabled delay line with a configurable reset value.
// Every stage resets, so the delayed output is defined during reset.
module enabledShiftRegister #(
  parameter int CYCLES = 1,
  parameter int WIDTH  = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  if (CYCLES < 1) begin : g_bad_cycles
    $error("enabledShiftRegister: CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] stage_q [CYCLES];

  // Shift one stage per enabled cycle; reset fills the whole chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CYCLES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else if (clkEn) begin
      stage_q[0] <= dataIn;
      for (int i = 1; i < CYCLES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dataOut = stage_q[CYCLES-1];

endmodule

// File: rtl/pipe_receive_fifo.sv
// Far-end receive buffer for a non-stallable hyperpiped link.
// FWFT output with valid/ready; delayed almost-full flag back to sender.
module pipe_receive_fifo
  import pipe_receive_fifo_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int DEPTH_LOG2     = DEF_DEPTH_LOG2,
  parameter int FORWARD_CYCLES = DEF_FORWARD_CYCLES,
  parameter int RETURN_CYCLES  = DEF_RETURN_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dataInValid,
  input  logic [WIDTH-1:0]      dataIn,
  output logic                  dataOutValid,
  output logic [WIDTH-1:0]      dataOut,
  input  logic                  dataOutReady,
  output logic                  almostFullUpstream,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic                  overflowError
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int THRESHOLD =
    calc_threshold(DEPTH_LOG2, FORWARD_CYCLES, RETURN_CYCLES);

  if (THRESHOLD < 1) begin : g_bad_threshold
    $error("pipe_receive_fifo: THRESHOLD < 1, buffer too shallow");
  end

  localparam logic [DEPTH_LOG2:0] DEPTH_W =
    {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] THR_W =
    THRESHOLD[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] ONE_W =
    {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE =
    {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   occ_q, occ_d;
  logic                  ovf_q, ovf_d;
  logic                  af_q, af_d;
  logic                  full, rd_en, wr_en;
  occ_op_e               op;

  assign full  = (occ_q == DEPTH_W);
  assign rd_en = dataOutValid & dataOutReady;
  // A full buffer still accepts when the head leaves the same cycle.
  assign wr_en = dataInValid & (~full | rd_en);
  assign op    = occ_op_e'({rd_en, wr_en});

  // Next pointers, occupancy, sticky overflow and threshold flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q | (dataInValid & ~wr_en);
    unique case (op)
      OP_WR: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        occ_d    = occ_q + ONE_W;
      end
      OP_RD: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        occ_d    = occ_q - ONE_W;
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      default: ;
    endcase
    af_d = (occ_d >= THR_W);
  end

  // Control state; reset drops all stored words and asserts the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      af_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      af_q     <= af_d;
    end
  end

  // Storage array, no reset so it can map to distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= dataIn;
    end
  end

  enabledShiftRegister #(
    .CYCLES      (RETURN_CYCLES),
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_return_pipe (
    .clk     (clk),
    .rst     (rst),
    .clkEn   (1'b1),
    .dataIn  (af_q),
    .dataOut (almostFullUpstream)
  );

  assign dataOutValid  = (occ_q != '0);
  assign dataOut       = mem_q[rd_ptr_q];
  assign occupancy     = occ_q;
  assign overflowError = ovf_q;

endmodule

// File: tb/tb_pipe_receive_fifo.sv
// Directed self-checking bench for pipe_receive_fifo.
// Inputs change 1ns after posedge; outputs sampled at the same point.
module tb_pipe_receive_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        dataInValid;
  logic [31:0] dataIn;
  logic        dataOutValid;
  logic [31:0] dataOut;
  logic        dataOutReady;
  logic        almostFullUpstream;
  logic [5:0]  occupancy;
  logic        overflowError;

  int checks = 0;
  int errors = 0;

  pipe_receive_fifo dut (
    .clk                (clk),
    .rst                (rst),
    .dataInValid        (dataInValid),
    .dataIn             (dataIn),
    .dataOutValid       (dataOutValid),
    .dataOut            (dataOut),
    .dataOutReady       (dataOutReady),
    .almostFullUpstream (almostFullUpstream),
    .occupancy          (occupancy),
    .overflowError      (overflowError)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dataInValid = 1'b0;
    dataOutReady = 1'b0;
    dataIn = '0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dataInValid = 1'b0;
    dataOutReady = 1'b0;
    dataIn = '0;
    step();
    checks++;
    if (almostFullUpstream !== 1'b1) begin
      errors++;
      $display("FAIL reset_af_in_rst: got %b want 1", almostFullUpstream);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (occupancy !== 6'd0) begin
      errors++;
      $display("FAIL reset_occ: got %0d want 0", occupancy);
    end
    checks++;
    if (dataOutValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", dataOutValid);
    end
    checks++;
    if (overflowError !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", overflowError);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (almostFullUpstream !== 1'b1) begin
        errors++;
        $display("FAIL reset_af_hold%0d: got %b want 1", i, almostFullUpstream);
      end
      step();
    end
    checks++;
    if (almostFullUpstream !== 1'b0) begin
      errors++;
      $display("FAIL reset_af_fall: got %b want 0", almostFullUpstream);
    end
  endtask

  task automatic test_single_word();
    dataOutReady = 1'b1;
    dataInValid = 1'b1;
    dataIn = 32'hDEADBEEF;
    step();
    dataInValid = 1'b0;
    checks++;
    if (dataOutValid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid: got %b want 1", dataOutValid);
    end
    checks++;
    if (dataOut !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_data: got %h want deadbeef", dataOut);
    end
    step();
    checks++;
    if (occupancy !== 6'd0 || dataOutValid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: occ %0d valid %b want 0 0",
               occupancy, dataOutValid);
    end
  endtask

  task automatic test_almost_full();
    dataOutReady = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      dataInValid = 1'b1;
      dataIn = i;
      step();
    end
    dataInValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (almostFullUpstream !== 1'b0) begin
        errors++;
        $display("FAIL af_23_low%0d: got %b want 0", i, almostFullUpstream);
      end
      step();
    end
    checks++;
    if (occupancy !== 6'd23) begin
      errors++;
      $display("FAIL af_occ23: got %0d want 23", occupancy);
    end
    dataInValid = 1'b1;
    dataIn = 24;
    step();
    dataInValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (almostFullUpstream !== 1'b0) begin
        errors++;
        $display("FAIL af_delay%0d: got %b want 0", i, almostFullUpstream);
      end
      step();
    end
    checks++;
    if (almostFullUpstream !== 1'b1) begin
      errors++;
      $display("FAIL af_rise: got %b want 1", almostFullUpstream);
    end
    dataOutReady = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      checks++;
      if (dataOutValid !== 1'b1 || dataOut !== 32'(i)) begin
        errors++;
        $display("FAIL af_drain%0d: valid %b data %0d want 1 %0d",
                 i, dataOutValid, dataOut, i);
      end
      step();
    end
    dataOutReady = 1'b0;
    checks++;
    if (occupancy !== 6'd0) begin
      errors++;
      $display("FAIL af_empty: got %0d want 0", occupancy);
    end
  endtask

  task automatic test_overflow();
    dataOutReady = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      dataInValid = 1'b1;
      dataIn = i;
      step();
    end
    dataInValid = 1'b0;
    checks++;
    if (occupancy !== 6'd32) begin
      errors++;
      $display("FAIL ovf_occ: got %0d want 32", occupancy);
    end
    checks++;
    if (overflowError !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got %b want 1", overflowError);
    end
    step();
    dataOutReady = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      checks++;
      if (dataOutValid !== 1'b1 || dataOut !== 32'(i)) begin
        errors++;
        $display("FAIL ovf_drain%0d: valid %b data %0d want 1 %0d",
                 i, dataOutValid, dataOut, i);
      end
      step();
    end
    dataOutReady = 1'b0;
    checks++;
    if (dataOutValid !== 1'b0 || occupancy !== 6'd0) begin
      errors++;
      $display("FAIL ovf_no33: valid %b occ %0d want 0 0",
               dataOutValid, occupancy);
    end
    checks++;
    if (overflowError !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 1", overflowError);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] exp;
    do_reset();
    dataOutReady = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dataInValid = 1'b1;
      dataIn = 32'h100 + i;
      q.push_back(32'h100 + i);
      step();
    end
    checks++;
    if (occupancy !== 6'd32) begin
      errors++;
      $display("FAIL b2b_full: got %0d want 32", occupancy);
    end
    dataOutReady = 1'b1;
    for (int k = 0; k < 40; k++) begin
      dataInValid = 1'b1;
      dataIn = 32'h200 + k;
      exp = q.pop_front();
      q.push_back(32'h200 + k);
      checks++;
      if (dataOut !== exp) begin
        errors++;
        $display("FAIL b2b_order%0d: got %h want %h", k, dataOut, exp);
      end
      step();
      checks++;
      if (occupancy !== 6'd32) begin
        errors++;
        $display("FAIL b2b_occ%0d: got %0d want 32", k, occupancy);
      end
    end
    dataInValid = 1'b0;
    checks++;
    if (overflowError !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ovf: got %b want 0", overflowError);
    end
    for (int k = 0; k < 32; k++) begin
      exp = q.pop_front();
      checks++;
      if (dataOutValid !== 1'b1 || dataOut !== exp) begin
        errors++;
        $display("FAIL b2b_drain%0d: valid %b got %h want %h",
                 k, dataOutValid, dataOut, exp);
      end
      step();
    end
    dataOutReady = 1'b0;
    checks++;
    if (occupancy !== 6'd0) begin
      errors++;
      $display("FAIL b2b_empty: got %0d want 0", occupancy);
    end
  endtask

  task automatic test_mid_reset();
    dataOutReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dataInValid = 1'b1;
      dataIn = 32'hA0 + i;
      step();
    end
    dataInValid = 1'b0;
    checks++;
    if (occupancy !== 6'd10) begin
      errors++;
      $display("FAIL mid_occ10: got %0d want 10", occupancy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (occupancy !== 6'd0 || dataOutValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_cleared: occ %0d valid %b want 0 0",
               occupancy, dataOutValid);
    end
    dataInValid = 1'b1;
    dataIn = 32'h55;
    step();
    dataInValid = 1'b0;
    checks++;
    if (dataOutValid !== 1'b1 || dataOut !== 32'h55) begin
      errors++;
      $display("FAIL mid_first: valid %b data %h want 1 55",
               dataOutValid, dataOut);
    end
    checks++;
    if (occupancy !== 6'd1) begin
      errors++;
      $display("FAIL mid_occ1: got %0d want 1", occupancy);
    end
  endtask

  initial begin
    rst = 1'b1;
    dataInValid = 1'b0;
    dataOutReady = 1'b0;
    dataIn = '0;
    test_reset();
    test_single_word();
    test_almost_full();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
